ah_rr_arb_mux: RTL and testbench

Packet-aware round-robin arbiter and mux that shares one valid/ready egress channel between NUM_ING ingress requesters. It is the arbitration counterpart of the AH demux: it collapses N streams onto one channel, while the demux fans one channel out to N. Once a requester is granted, the grant is held until that requester's end-of-packet beat is transferred. The block has a single-entry registered output stage.

---
 rtl/ah_rr_arb_mux.sv | 129 ++++++++++++
 tb/tb_ah_rr_arb_mux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ah_rr_arb_mux.sv
// Packet-aware round-robin arbiter/mux: NUM_ING valid/ready streams onto one registered
// egress channel, holding the grant from a packet's first beat through its EOP beat.
module ah_rr_arb_mux #(
  parameter int unsigned NUM_ING = 4,
  parameter int unsigned DATA_W  = 34,
  parameter int unsigned EOP_BIT = 33,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_ING*DATA_W-1:0] ing_data,
  input  logic [NUM_ING-1:0]        ing_valid,
  output logic [NUM_ING-1:0]        ing_ready,
  output logic [DATA_W-1:0]         egr_data,
  output logic                      egr_valid,
  input  logic                      egr_ready,
  output logic [SEL_W-1:0]          egr_src,
  output logic                      busy
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e              r_state, w_state_d;
  logic [SEL_W-1:0]    r_rr_ptr, w_rr_ptr_d;
  logic [SEL_W-1:0]    r_cur_grant, w_cur_grant_d;
  logic [DATA_W-1:0]   r_egr_data;
  logic [SEL_W-1:0]    r_egr_src;
  logic                r_egr_valid;

  logic                w_found;
  logic [SEL_W-1:0]    w_winner;
  logic [SEL_W-1:0]    w_sel;
  logic                w_req;
  logic                w_slot_free;
  logic                w_xfer;
  logic                w_eop;
  logic [DATA_W-1:0]   w_beat;

  function automatic logic [SEL_W-1:0] f_wrap(input logic [SEL_W-1:0] base,
                                              input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_ING;
    return SEL_W'(sum);
  endfunction

  // Rotating priority encoder: first valid requester at or after r_rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_ING; k++) begin
      if (!w_found && ing_valid[f_wrap(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = f_wrap(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_slot_free = !r_egr_valid || egr_ready;
    w_sel       = (r_state == StLocked) ? r_cur_grant : w_winner;
    w_req       = (r_state == StLocked) ? 1'b1 : w_found;
    w_xfer      = w_req && w_slot_free && ing_valid[w_sel];
    ing_ready   = '0;
    if (w_req && w_slot_free && !rst) begin
      ing_ready = NUM_ING'(1) << w_sel;
    end
  end

  always_comb begin
    w_beat = '0;
    for (int unsigned i = 0; i < NUM_ING; i++) begin
      if (w_sel == SEL_W'(i)) begin
        w_beat = ing_data[i*DATA_W +: DATA_W];
      end
    end
    w_eop = w_beat[EOP_BIT];
  end

  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_cur_grant_d = r_cur_grant;
    unique case (r_state)
      StIdle: begin
        if (w_xfer && w_eop) begin
          w_rr_ptr_d = f_wrap(w_winner, 1);
        end else if (w_xfer) begin
          w_state_d     = StLocked;
          w_cur_grant_d = w_winner;
        end
      end
      StLocked: begin
        if (w_xfer && w_eop) begin
          w_state_d  = StIdle;
          w_rr_ptr_d = f_wrap(r_cur_grant, 1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_cur_grant <= '0;
      r_egr_data  <= '0;
      r_egr_src   <= '0;
      r_egr_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_cur_grant <= w_cur_grant_d;
      if (w_xfer) begin
        r_egr_data  <= w_beat;
        r_egr_src   <= w_sel;
        r_egr_valid <= 1'b1;
      end else if (egr_ready) begin
        r_egr_valid <= 1'b0;
      end
    end
  end

  assign egr_data  = r_egr_data;
  assign egr_src   = r_egr_src;
  assign egr_valid = r_egr_valid;
  assign busy      = (r_state == StLocked);

endmodule

// File: tb/tb_ah_rr_arb_mux.sv
// Bench for ah_rr_arb_mux: a cycle model predicts grants and pushes expected egress beats
// into a queue; a vector table and hand sequences cover fairness, locking, stalls and reset.
module tb_ah_rr_arb_mux;

  localparam int N  = 4;
  localparam int DW = 34;

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] ing_data;
  logic [N-1:0]    ing_valid;
  logic [N-1:0]    ing_ready;
  logic [DW-1:0]   egr_data;
  logic            egr_valid;
  logic            egr_ready;
  logic [1:0]      egr_src;
  logic            busy;

  ah_rr_arb_mux #(
    .NUM_ING(N), .DATA_W(DW), .EOP_BIT(33), .SEL_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ing_data  (ing_data),
    .ing_valid (ing_valid),
    .ing_ready (ing_ready),
    .egr_data  (egr_data),
    .egr_valid (egr_valid),
    .egr_ready (egr_ready),
    .egr_src   (egr_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] eop;
    logic       rdy;
    logic [3:0] exp_rdy;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    s;
  } exp_t;

  vec_t tbl[12];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model state
  bit       m_lock;
  bit       m_vld;
  int       m_ptr;
  int       m_grant;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] e, input logic r);
    cyc++;
    for (int i = 0; i < N; i++) ing_data[i*DW +: DW] = {e[i], 1'b0, 8'(i), 24'(cyc)};
    ing_valid = v;
    egr_ready = r;
  endtask

  task automatic model_reset();
    m_lock = 0; m_vld = 0; m_ptr = 0; m_grant = 0;
    q.delete();
  endtask

  // Called at posedge+1: checks at the falling edge, advances the model, ends at posedge+1.
  task automatic step(input bit use_exp, input logic [3:0] exp_rdy, input string tag);
    logic [3:0] er;
    bit         req, sf, xfer;
    int         sel;
    exp_t       e;
    #4;
    sf  = !m_vld || egr_ready;
    req = 0;
    sel = 0;
    if (m_lock) begin
      req = 1;
      sel = m_grant;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!req && ing_valid[(m_ptr + k) % N]) begin
          req = 1;
          sel = (m_ptr + k) % N;
        end
      end
    end
    er = (req && sf) ? 4'(1 << sel) : 4'b0;
    chk({tag, "/ready"}, 64'(ing_ready), 64'(er));
    if (use_exp) chk({tag, "/tbl_ready"}, 64'(ing_ready), 64'(exp_rdy));
    chk({tag, "/busy"}, 64'(busy), 64'(m_lock));
    chk({tag, "/egr_valid"}, 64'(egr_valid), 64'(m_vld));
    if (m_vld) begin
      chk({tag, "/sb_depth"}, 64'(q.size()), 64'd1);
      if (q.size() > 0) begin
        chk({tag, "/egr_data"}, 64'(egr_data), 64'(q[0].d));
        chk({tag, "/egr_src"}, 64'(egr_src), 64'(q[0].s));
      end
    end
    xfer = req && sf && ing_valid[sel];
    if (m_vld && egr_ready && q.size() > 0) void'(q.pop_front());
    if (xfer) begin
      e.d = ing_data[sel*DW +: DW];
      e.s = 2'(sel);
      q.push_back(e);
      if (e.d[33]) begin
        m_lock = 0;
        m_ptr  = (sel + 1) % N;
      end else begin
        m_lock  = 1;
        m_grant = sel;
      end
    end
    m_vld = xfer ? 1'b1 : (egr_ready ? 1'b0 : m_vld);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1);
    #2;
    chk("rst/ing_ready", 64'(ing_ready), 64'd0);
    chk("rst/egr_valid", 64'(egr_valid), 64'd0);
    chk("rst/egr_data", 64'(egr_data), 64'd0);
    chk("rst/egr_src", 64'(egr_src), 64'd0);
    chk("rst/busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{4'b1001, 4'b1111, 1'b1, 4'b1000};
    tbl[7]  = '{4'b1001, 4'b1111, 1'b1, 4'b0001};
    tbl[8]  = '{4'b0010, 4'b1111, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0010, 4'b1111, 1'b0, 4'b0000};
    tbl[10] = '{4'b0010, 4'b1111, 1'b1, 4'b0010};
    tbl[11] = '{4'b0000, 4'b1111, 1'b1, 4'b0000};

    model_reset();
    do_reset();

    // Requester 2 alone, 3-beat packet; then 0 and 3 contend with the pointer at 3.
    drive(4'b0100, 4'b0000, 1'b1); step(1, 4'b0100, "t1_a0");
    drive(4'b0100, 4'b0000, 1'b1); step(1, 4'b0100, "t1_a1");
    drive(4'b0100, 4'b0100, 1'b1); step(1, 4'b0100, "t1_a2");
    drive(4'b1001, 4'b1111, 1'b1); step(1, 4'b1000, "t5_w3");
    drive(4'b1001, 4'b1111, 1'b1); step(1, 4'b0001, "t5_w0");
    drive(4'b0000, 4'b0000, 1'b1); step(0, 4'b0000, "t5_drain");

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vld, tbl[i].eop, tbl[i].rdy);
      step(1, tbl[i].exp_rdy, $sformatf("tbl%0d", i));
    end

    // 4-beat packet on req0 with a 2-cycle bubble; req1 waits throughout.
    drive(4'b0011, 4'b0010, 1'b1); step(1, 4'b0001, "t3_b0");
    drive(4'b0011, 4'b0010, 1'b1); step(1, 4'b0001, "t3_b1");
    drive(4'b0010, 4'b0010, 1'b1); step(1, 4'b0001, "t3_bub0");
    drive(4'b0010, 4'b0010, 1'b1); step(1, 4'b0001, "t3_bub1");
    drive(4'b0011, 4'b0010, 1'b1); step(1, 4'b0001, "t3_b2");
    drive(4'b0011, 4'b0011, 1'b1); step(1, 4'b0001, "t3_b3");
    drive(4'b0010, 4'b0010, 1'b1); step(1, 4'b0010, "t3_r1");

    // Egress stall for 5 cycles, then drain and reload in one cycle.
    drive(4'b0100, 4'b1111, 1'b1); step(1, 4'b0100, "t4_load");
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 4'b1111, 1'b0); step(1, 4'b0000, $sformatf("t4_stall%0d", i));
    end
    drive(4'b0100, 4'b1111, 1'b1); step(1, 4'b0100, "t4_reload");
    drive(4'b0000, 4'b0000, 1'b1); step(0, 4'b0000, "t4_drain0");
    drive(4'b0000, 4'b0000, 1'b1); step(0, 4'b0000, "t4_drain1");

    // Reset asserted while locked with a beat in the output register.
    drive(4'b0010, 4'b0000, 1'b0); step(1, 4'b0010, "t6_lock");
    chk("t6/busy_pre", 64'(busy), 64'd1);
    chk("t6/valid_pre", 64'(egr_valid), 64'd1);
    egr_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6/egr_valid", 64'(egr_valid), 64'd0);
    chk("t6/busy", 64'(busy), 64'd0);
    chk("t6/ing_ready", 64'(ing_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(4'b1111, 4'b1111, 1'b1); step(1, 4'b0001, "t6_first");
    drive(4'b1111, 4'b1111, 1'b1); step(1, 4'b0010, "t6_second");
    drive(4'b0000, 4'b0000, 1'b1); step(0, 4'b0000, "end_drain0");
    drive(4'b0000, 4'b0000, 1'b1); step(0, 4'b0000, "end_drain1");
    chk("end/sb_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
